// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encodings and the default debounce length.
// Reused by the control unit and by datapath-side display/LED logic.
package stopwatch_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 100000;

    localparam logic [1:0] STATE_STOP  = 2'd0;
    localparam logic [1:0] STATE_RUN   = 2'd1;
    localparam logic [1:0] STATE_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        StStop    = STATE_STOP,
        StRun     = STATE_RUN,
        StClear   = STATE_CLEAR,
        StIllegal = 2'd3
    } sw_state_e;

endpackage

// File: rtl/stopwatch_cu_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce counter and
// a one-cycle pulse on each accepted press (debounced 0->1).
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synced input agrees with the accepted level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= i_btn;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;
        end
    end

    assign o_level = level_q;
    assign o_pulse = pulse_q;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: conditions the run and clear buttons and runs the
// STOP/RUN/CLEAR FSM that drives the datapath run level and clear strobe.
module stopwatch_cu
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    output logic       o_run,
    output logic       o_clear,
    output logic [1:0] o_state
);

    logic      run_level, run_pulse;
    logic      clear_level, clear_pulse;
    logic      unused_levels;
    sw_state_e state_q, state_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (i_btn_run),
        .o_level (run_level),
        .o_pulse (run_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clear_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (i_btn_clear),
        .o_level (clear_level),
        .o_pulse (clear_pulse)
    );

    // Debounced levels are only of interest to debug probes.
    assign unused_levels = run_level ^ clear_level;

    // Clear takes priority in STOP; in RUN only run/stop is honoured.
    always_comb begin
        state_d = StStop;
        case (state_q)
            StStop: begin
                if (clear_pulse) begin
                    state_d = StClear;
                end else if (run_pulse) begin
                    state_d = StRun;
                end else begin
                    state_d = StStop;
                end
            end
            StRun:   state_d = run_pulse ? StStop : StRun;
            StClear: state_d = StStop;
            default: state_d = StStop;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StStop;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_run   = (state_q == StRun);
    assign o_clear = (state_q == StClear);
    assign o_state = state_q;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Self-checking bench for stopwatch_cu with a short debounce, directed scenarios
// plus randomised button activity checked against a behavioural model.
module tb_stopwatch_cu;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_btn_run = 1'b0;
    logic       i_btn_clear = 1'b0;
    logic       o_run, o_clear;
    logic [1:0] o_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stopwatch_cu #(
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_run   (i_btn_run),
        .i_btn_clear (i_btn_clear),
        .o_run       (o_run),
        .o_clear     (o_clear),
        .o_state     (o_state)
    );

    // Behavioural model: sample history, mismatch streaks, press events, mode.
    bit         qr[$], qc[$];
    int         deb_r, deb_c, str_r, str_c;
    bit         rise_r1, rise_r2, rise_c1, rise_c2;
    int         m_st;
    logic [1:0] m_state;
    logic       m_run, m_clear;

    function automatic bit deb_step(input bit syn, inout int deb, inout int str);
        if (int'(syn) != deb) begin
            str++;
            if (str == int'(DB)) begin
                deb = int'(syn);
                str = 0;
                return syn;
            end
        end else begin
            str = 0;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        bit sr, sc, nr, nc;
        if (rst) begin
            qr.delete(); qc.delete();
            deb_r = 0; deb_c = 0; str_r = 0; str_c = 0;
            rise_r1 = 0; rise_r2 = 0; rise_c1 = 0; rise_c2 = 0;
            m_st = 0;
        end else begin
            case (m_st)
                0: if (rise_c2) m_st = 2; else if (rise_r2) m_st = 1;
                1: if (rise_r2) m_st = 0;
                default: m_st = 0;
            endcase
            qr.push_back(i_btn_run);
            qc.push_back(i_btn_clear);
            sr = (qr.size() >= 3) ? qr[qr.size()-3] : 1'b0;
            sc = (qc.size() >= 3) ? qc[qc.size()-3] : 1'b0;
            if (qr.size() > 3) void'(qr.pop_front());
            if (qc.size() > 3) void'(qc.pop_front());
            nr = deb_step(sr, deb_r, str_r);
            nc = deb_step(sc, deb_c, str_c);
            rise_r2 = rise_r1; rise_r1 = nr;
            rise_c2 = rise_c1; rise_c1 = nc;
        end
        m_state = 2'(m_st);
        m_run   = (m_st == 1);
        m_clear = (m_st == 2);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_btn_run = 1'b0; i_btn_clear = 1'b0;
        repeat (3) begin
            tick();
            n_tests++;
            if ({o_run, o_clear, o_state} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset: got run=%b clear=%b state=%0d, want 0/0/0",
                         o_run, o_clear, o_state);
            end
        end
        rst = 1'b0;
        repeat (6) begin
            tick();
            n_tests++;
            if ({o_run, o_clear, o_state} !== {m_run, m_clear, m_state}) begin
                n_fail++;
                $display("FAIL reset_idle: got %b%b/%0d, want %b%b/%0d",
                         o_run, o_clear, o_state, m_run, m_clear, m_state);
            end
        end
    endtask

    task automatic test_run_toggle();
        for (int p = 0; p < 2; p++) begin
            i_btn_run = 1'b1;
            for (int i = 0; i < 20; i++) begin
                logic exp_run;
                tick();
                exp_run = (p == 0) ? (i >= 7) : (i < 7);
                n_tests++;
                if (o_run !== exp_run || o_state !== {1'b0, exp_run}
                    || o_state !== m_state) begin
                    n_fail++;
                    $display("FAIL run_toggle p%0d i%0d: got run=%b state=%0d, want run=%b model=%0d",
                             p, i, o_run, o_state, exp_run, m_state);
                end
            end
            i_btn_run = 1'b0;
            repeat (12) tick();
        end
    endtask

    task automatic test_glitch();
        i_btn_run = 1'b1;
        repeat (3) tick();
        i_btn_run = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_tests++;
            if (o_state !== 2'd0 || m_state !== 2'd0) begin
                n_fail++;
                $display("FAIL glitch i%0d: got state=%0d, want 0 (model %0d)", i, o_state, m_state);
            end
        end
    endtask

    task automatic test_clear();
        int clr_cnt = 0;
        i_btn_clear = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_clear === 1'b1) clr_cnt++;
            n_tests++;
            if (o_clear !== (i == 7) || o_state !== ((i == 7) ? 2'd2 : 2'd0) || o_run !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_stop i%0d: got clear=%b state=%0d run=%b", i, o_clear, o_state, o_run);
            end
        end
        n_tests++;
        if (clr_cnt !== 1) begin
            n_fail++;
            $display("FAIL clear_once: got %0d clear cycles, want 1", clr_cnt);
        end
        i_btn_clear = 1'b0;
        repeat (12) tick();
        i_btn_run = 1'b1;
        repeat (20) tick();
        i_btn_run = 1'b0;
        repeat (12) tick();
        i_btn_clear = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            n_tests++;
            if (o_run !== 1'b1 || o_clear !== 1'b0 || o_state !== m_state) begin
                n_fail++;
                $display("FAIL clear_in_run i%0d: got run=%b clear=%b state=%0d, want 1/0/%0d",
                         i, o_run, o_clear, o_state, m_state);
            end
        end
        i_btn_clear = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_simultaneous();
        int clr_cnt, run_cnt;
        // Leave RUN first so both buttons hit STOP.
        i_btn_run = 1'b1;
        repeat (20) tick();
        i_btn_run = 1'b0;
        repeat (12) tick();
        n_tests++;
        if (o_state !== 2'd0) begin
            n_fail++;
            $display("FAIL simul_pre: got state=%0d, want 0", o_state);
        end
        for (int p = 0; p < 2; p++) begin
            clr_cnt = 0; run_cnt = 0;
            i_btn_run = 1'b1; i_btn_clear = 1'b1;
            repeat (20) begin
                tick();
                if (o_clear === 1'b1) clr_cnt++;
                if (o_run === 1'b1) run_cnt++;
                n_tests++;
                if ({o_run, o_clear, o_state} !== {m_run, m_clear, m_state}) begin
                    n_fail++;
                    $display("FAIL simul_model p%0d: got %b%b/%0d, want %b%b/%0d",
                             p, o_run, o_clear, o_state, m_run, m_clear, m_state);
                end
            end
            i_btn_run = 1'b0; i_btn_clear = 1'b0;
            repeat (12) tick();
            n_tests++;
            if ((p == 0 && (clr_cnt != 1 || run_cnt != 0))
                || (p == 1 && (clr_cnt != 0 || run_cnt != 7 || o_state !== 2'd0))) begin
                n_fail++;
                $display("FAIL simul p%0d: got clear_cycles=%0d run_cycles=%0d state=%0d",
                         p, clr_cnt, run_cnt, o_state);
            end
            if (p == 0) begin
                i_btn_run = 1'b1;
                repeat (20) tick();
                i_btn_run = 1'b0;
                repeat (12) tick();
                // RUN for 7 cycles before the combined press stops it.
                n_tests++;
                if (o_run !== 1'b1) begin
                    n_fail++;
                    $display("FAIL simul_run_setup: got run=%b, want 1", o_run);
                end
                run_cnt = 0;
            end
        end
    endtask

    task automatic test_reset_held();
        i_btn_run = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (o_run !== 1'b0 || o_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_held_rst: got run=%b state=%0d, want 0/0", o_run, o_state);
        end
        for (int i = 1; i <= 30; i++) begin
            tick();
            n_tests++;
            if (o_run !== (i >= 8) || o_run !== m_run) begin
                n_fail++;
                $display("FAIL reset_held i%0d: got run=%b, want %b (model %b)",
                         i, o_run, (i >= 8), m_run);
            end
        end
        i_btn_run = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_random();
        int hold_r = 0, hold_c = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold_r == 0) begin
                i_btn_run = 1'($urandom_range(0, 1));
                hold_r = $urandom_range(1, 12);
            end
            if (hold_c == 0) begin
                i_btn_clear = 1'($urandom_range(0, 1));
                hold_c = $urandom_range(1, 12);
            end
            hold_r--; hold_c--;
            rst = ($urandom_range(0, 299) == 0);
            tick();
            n_tests++;
            if ({o_run, o_clear, o_state} !== {m_run, m_clear, m_state}
                || (o_run === 1'b1 && o_clear === 1'b1)) begin
                n_fail++;
                $display("FAIL random i%0d: got run=%b clear=%b state=%0d, want %b/%b/%0d",
                         i, o_run, o_clear, o_state, m_run, m_clear, m_state);
            end
        end
        rst = 1'b0; i_btn_run = 1'b0; i_btn_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_toggle();
        test_glitch();
        test_clear();
        test_simultaneous();
        test_reset_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
